decode_issue: RTL and testbench

- Instruction decode and issue stage sitting directly upstream of the register file and downstream of fetch.
- Accepts one RV32I instruction and drives the register file read addresses from it.
- Captures the register file's registered read data and tracks outstanding writes with a 32-entry scoreboard to stall RAW/WAW hazards.
- Presents a decoded, operand-complete bundle to execute under a valid/ready handshake.

---
 rtl/decode_issue_if.sv | 34 +++
 rtl/decode_issue.sv | 194 +++++++++++++++++++
 tb/tb_decode_issue.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/decode_issue_if.sv
// Fetch-side and execute-side handshake bundle for the decode/issue stage.
// slave is the stage's view; master is the surrounding pipeline's view.
interface decode_issue_if #(
    parameter int XLEN = 32
);
    logic            if_valid;
    logic [31:0]     if_instr;
    logic [XLEN-1:0] if_pc;
    logic            if_ready;

    logic            out_valid;
    logic            ex_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_rs1_data;
    logic [XLEN-1:0] out_rs2_data;
    logic [4:0]      out_rd;
    logic [2:0]      out_funct3;
    logic            out_funct7b5;
    logic [3:0]      out_opclass;
    logic [XLEN-1:0] out_imm;
    logic            out_illegal;

    modport slave (
        input  if_valid, if_instr, if_pc, ex_ready,
        output if_ready, out_valid, out_pc, out_rs1_data, out_rs2_data, out_rd,
               out_funct3, out_funct7b5, out_opclass, out_imm, out_illegal
    );

    modport master (
        output if_valid, if_instr, if_pc, ex_ready,
        input  if_ready, out_valid, out_pc, out_rs1_data, out_rs2_data, out_rd,
               out_funct3, out_funct7b5, out_opclass, out_imm, out_illegal
    );
endinterface

// File: rtl/decode_issue.sv
// RV32I decode/issue stage: drives regfile read addresses, captures operands,
// and stalls RAW/WAW hazards against a per-register pending-write scoreboard.
//
// state  | meaning
// IDLE   | waiting for fetch; if_ready high unless flushing
// DECODE | read addresses driven; stall here while a hazard exists
// READ   | regfile sampling addresses; data captured on exit
// ISSUE  | bundle valid, held until ex_ready
module decode_issue #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    output logic [4:0]       read_reg1,
    output logic [4:0]       read_reg2,
    input  logic [XLEN-1:0]  reg_data1,
    input  logic [XLEN-1:0]  reg_data2,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    decode_issue_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, DECODE, READ, ISSUE} state_t;

    state_t          state_q, state_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [NREG-1:0] pending_q, pending_d;

    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d;
    logic [XLEN-1:0] rs1_data_q, rs1_data_d;
    logic [XLEN-1:0] rs2_data_q, rs2_data_d;
    logic [4:0]      out_rd_q, out_rd_d;
    logic [2:0]      funct3_q, funct3_d;
    logic            funct7b5_q, funct7b5_d;
    logic [3:0]      opclass_q, opclass_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic            illegal_q, illegal_d;

    logic [3:0]      dec_opclass;
    logic [XLEN-1:0] dec_imm;
    logic            uses_rs1, uses_rs2, writes_rd, dec_illegal;
    logic [4:0]      rs1, rs2, rd;
    logic            hazard, if_ready, issue_fire;

    assign rs1 = instr_q[19:15];
    assign rs2 = instr_q[24:20];
    assign rd  = instr_q[11:7];

    always_comb begin
        dec_opclass = 4'd15;
        dec_imm     = '0;
        uses_rs1    = 1'b0;
        uses_rs2    = 1'b0;
        writes_rd   = 1'b0;
        dec_illegal = 1'b0;
        case (instr_q[6:0])
            7'b0110111: begin dec_opclass = 4'd0; writes_rd = 1'b1;
                              dec_imm = {instr_q[31:12], 12'b0}; end
            7'b0010111: begin dec_opclass = 4'd1; writes_rd = 1'b1;
                              dec_imm = {instr_q[31:12], 12'b0}; end
            7'b1101111: begin dec_opclass = 4'd2; writes_rd = 1'b1;
                              dec_imm = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12],
                                         instr_q[20], instr_q[30:21], 1'b0}; end
            7'b1100111: begin dec_opclass = 4'd3; writes_rd = 1'b1; uses_rs1 = 1'b1;
                              dec_imm = {{20{instr_q[31]}}, instr_q[31:20]}; end
            7'b1100011: begin dec_opclass = 4'd4; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
                              dec_imm = {{19{instr_q[31]}}, instr_q[31], instr_q[7],
                                         instr_q[30:25], instr_q[11:8], 1'b0}; end
            7'b0000011: begin dec_opclass = 4'd5; writes_rd = 1'b1; uses_rs1 = 1'b1;
                              dec_imm = {{20{instr_q[31]}}, instr_q[31:20]}; end
            7'b0100011: begin dec_opclass = 4'd6; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
                              dec_imm = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]}; end
            7'b0010011: begin dec_opclass = 4'd7; writes_rd = 1'b1; uses_rs1 = 1'b1;
                              dec_imm = {{20{instr_q[31]}}, instr_q[31:20]}; end
            7'b0110011: begin dec_opclass = 4'd8; writes_rd = 1'b1;
                              uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            default:    dec_illegal = 1'b1;
        endcase
    end

    // Mask is the registered copy, so a writeback frees DECODE one cycle later.
    assign hazard = (uses_rs1 & pending_q[rs1]) | (uses_rs2 & pending_q[rs2]) |
                    (writes_rd & pending_q[rd]);

    assign if_ready   = ~rst & ~flush & (state_q == IDLE);
    assign issue_fire = (state_q == ISSUE) & bus.ex_ready & ~flush;

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        pc_d        = pc_q;
        out_valid_d = out_valid_q;
        out_pc_d    = out_pc_q;
        rs1_data_d  = rs1_data_q;
        rs2_data_d  = rs2_data_q;
        out_rd_d    = out_rd_q;
        funct3_d    = funct3_q;
        funct7b5_d  = funct7b5_q;
        opclass_d   = opclass_q;
        imm_d       = imm_q;
        illegal_d   = illegal_q;
        if (flush) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.if_valid && if_ready) begin
                    instr_d = bus.if_instr;
                    pc_d    = bus.if_pc;
                    state_d = DECODE;
                end
                DECODE: if (!hazard) state_d = READ;
                READ: begin
                    state_d     = ISSUE;
                    out_valid_d = 1'b1;
                    out_pc_d    = pc_q;
                    rs1_data_d  = uses_rs1 ? reg_data1 : '0;
                    rs2_data_d  = uses_rs2 ? reg_data2 : '0;
                    out_rd_d    = writes_rd ? rd : 5'd0;
                    funct3_d    = instr_q[14:12];
                    funct7b5_d  = instr_q[30];
                    opclass_d   = dec_opclass;
                    imm_d       = dec_imm;
                    illegal_d   = dec_illegal;
                end
                ISSUE: if (bus.ex_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Set is applied after clear so a same-cycle issue of the same rd wins.
    always_comb begin
        pending_d = pending_q;
        if (wb_valid) pending_d[wb_rd] = 1'b0;
        if (issue_fire && out_rd_q != 5'd0) pending_d[out_rd_q] = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            instr_q     <= '0;
            pc_q        <= '0;
            pending_q   <= '0;
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            out_rd_q    <= '0;
            funct3_q    <= '0;
            funct7b5_q  <= 1'b0;
            opclass_q   <= '0;
            imm_q       <= '0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            pc_q        <= pc_d;
            pending_q   <= pending_d;
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            rs1_data_q  <= rs1_data_d;
            rs2_data_q  <= rs2_data_d;
            out_rd_q    <= out_rd_d;
            funct3_q    <= funct3_d;
            funct7b5_q  <= funct7b5_d;
            opclass_q   <= opclass_d;
            imm_q       <= imm_d;
            illegal_q   <= illegal_d;
        end
    end

    assign read_reg1 = (state_q != IDLE && uses_rs1) ? rs1 : 5'd0;
    assign read_reg2 = (state_q != IDLE && uses_rs2) ? rs2 : 5'd0;

    assign bus.if_ready     = if_ready;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_pc       = out_pc_q;
    assign bus.out_rs1_data = rs1_data_q;
    assign bus.out_rs2_data = rs2_data_q;
    assign bus.out_rd       = out_rd_q;
    assign bus.out_funct3   = funct3_q;
    assign bus.out_funct7b5 = funct7b5_q;
    assign bus.out_opclass  = opclass_q;
    assign bus.out_imm      = imm_q;
    assign bus.out_illegal  = illegal_q;
endmodule

// File: tb/tb_decode_issue.sv
// Directed bench for decode_issue: latency, hazard stall, ex stall, flush,
// illegal/store decode and asynchronous reset, against hand-computed values.
module tb_decode_issue;
    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [4:0]  read_reg1, read_reg2;
    logic [31:0] reg_data1, reg_data2;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] rf [32];
    int          tests_run = 0;
    int          tests_failed = 0;

    decode_issue_if bus ();

    decode_issue dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .read_reg1 (read_reg1),
        .read_reg2 (read_reg2),
        .reg_data1 (reg_data1),
        .reg_data2 (reg_data2),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Registered register-file model: rf[i] = i * 0x11.
    always @(posedge clk) begin
        reg_data1 <= rf[read_reg1];
        reg_data2 <= rf[read_reg2];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] ins, input logic [31:0] pc);
        bus.if_valid = 1'b1;
        bus.if_instr = ins;
        bus.if_pc    = pc;
        @(negedge clk);
        bus.if_valid = 1'b0;
    endtask

    task automatic handshake();
        bus.ex_ready = 1'b1;
        @(negedge clk);
        bus.ex_ready = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = i * 32'h11;
        rst = 1'b1; flush = 1'b0; wb_valid = 1'b0; wb_rd = '0;
        bus.if_valid = 1'b0; bus.if_instr = '0; bus.if_pc = '0; bus.ex_ready = 1'b0;
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_if_ready", 32'(bus.if_ready), 0);
        check("rst_mask", dut.pending_q, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_rel_if_ready", 32'(bus.if_ready), 1);

        // ADDI x5,x1,-3
        @(negedge clk);
        send(32'hFFD08293, 32'h100);
        check("addi_rr1", 32'(read_reg1), 1);
        check("addi_rr2", 32'(read_reg2), 0);
        check("addi_busy", 32'(bus.if_ready), 0);
        check("addi_e0_valid", 32'(bus.out_valid), 0);
        @(negedge clk);
        check("addi_e1_valid", 32'(bus.out_valid), 0);
        @(negedge clk);
        check("addi_e2_valid", 32'(bus.out_valid), 1);
        check("addi_pc", bus.out_pc, 32'h100);
        check("addi_imm", bus.out_imm, 32'hFFFFFFFD);
        check("addi_rd", 32'(bus.out_rd), 5);
        check("addi_opc", 32'(bus.out_opclass), 7);
        check("addi_rs1", bus.out_rs1_data, 32'h11);
        check("addi_rs2", bus.out_rs2_data, 0);
        check("addi_ill", 32'(bus.out_illegal), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(bus.out_valid), 1);
            check("stall_imm", bus.out_imm, 32'hFFFFFFFD);
            check("stall_rs1", bus.out_rs1_data, 32'h11);
            check("stall_rd", 32'(bus.out_rd), 5);
            check("stall_if_ready", 32'(bus.if_ready), 0);
        end
        handshake();
        check("hs_valid", 32'(bus.out_valid), 0);
        check("hs_if_ready", 32'(bus.if_ready), 1);
        check("hs_mask_x5", dut.pending_q, 32'h20);

        // ADD x6,x5,x2: RAW on x5
        send(32'h00228333, 32'h200);
        check("add_rr1", 32'(read_reg1), 5);
        check("add_rr2", 32'(read_reg2), 2);
        repeat (3) @(negedge clk);
        check("add_held", 32'(dut.state_q), 1);
        check("add_held_valid", 32'(bus.out_valid), 0);
        wb_valid = 1'b1; wb_rd = 5'd5;
        @(negedge clk);
        wb_valid = 1'b0;
        check("wb_mask_clr", dut.pending_q, 0);
        check("wb_still_decode", 32'(dut.state_q), 1);
        @(negedge clk);
        check("add_read", 32'(dut.state_q), 2);
        @(negedge clk);
        check("add_valid", 32'(bus.out_valid), 1);
        check("add_rs1", bus.out_rs1_data, 32'h55);
        check("add_rs2", bus.out_rs2_data, 32'h22);
        check("add_rd", 32'(bus.out_rd), 6);
        check("add_opc", 32'(bus.out_opclass), 8);
        check("add_imm", bus.out_imm, 0);
        check("add_pc", bus.out_pc, 32'h200);
        handshake();
        check("add_mask_x6", dut.pending_q, 32'h40);

        // ADDI x7,x1,1 flushed in READ
        send(32'h00108393, 32'h300);
        @(negedge clk);
        check("fl_in_read", 32'(dut.state_q), 2);
        flush = 1'b1;
        #1;
        check("fl_if_ready", 32'(bus.if_ready), 0);
        @(negedge clk);
        flush = 1'b0;
        check("fl_idle", 32'(dut.state_q), 0);
        check("fl_valid", 32'(bus.out_valid), 0);
        check("fl_mask", dut.pending_q, 32'h40);
        @(negedge clk);
        check("fl_valid2", 32'(bus.out_valid), 0);
        check("fl_if_ready2", 32'(bus.if_ready), 1);

        // Illegal word
        send(32'hFFFFFFFF, 32'h400);
        check("ill_rr1", 32'(read_reg1), 0);
        check("ill_rr2", 32'(read_reg2), 0);
        repeat (2) @(negedge clk);
        check("ill_valid", 32'(bus.out_valid), 1);
        check("ill_flag", 32'(bus.out_illegal), 1);
        check("ill_opc", 32'(bus.out_opclass), 15);
        check("ill_rd", 32'(bus.out_rd), 0);
        check("ill_imm", bus.out_imm, 0);
        handshake();
        check("ill_mask", dut.pending_q, 32'h40);

        // SW x2,8(x1)
        send(32'h0020A423, 32'h500);
        repeat (2) @(negedge clk);
        check("sw_valid", 32'(bus.out_valid), 1);
        check("sw_imm", bus.out_imm, 8);
        check("sw_opc", 32'(bus.out_opclass), 6);
        check("sw_rd", 32'(bus.out_rd), 0);
        check("sw_f3", 32'(bus.out_funct3), 2);
        check("sw_rs1", bus.out_rs1_data, 32'h11);
        check("sw_rs2", bus.out_rs2_data, 32'h22);
        handshake();
        check("sw_mask", dut.pending_q, 32'h40);

        // Asynchronous reset while in ISSUE
        send(32'hFFD08293, 32'h600);
        repeat (2) @(negedge clk);
        check("ar_valid_pre", 32'(bus.out_valid), 1);
        #2 rst = 1'b1;
        #1;
        check("ar_valid", 32'(bus.out_valid), 0);
        check("ar_pc", bus.out_pc, 0);
        check("ar_imm", bus.out_imm, 0);
        check("ar_rs1", bus.out_rs1_data, 0);
        check("ar_rd", 32'(bus.out_rd), 0);
        check("ar_opc", 32'(bus.out_opclass), 0);
        check("ar_mask", dut.pending_q, 0);
        check("ar_if_ready", 32'(bus.if_ready), 0);
        check("ar_rr1", 32'(read_reg1), 0);
        #1 rst = 1'b0;
        @(negedge clk);
        check("ar_rel_if_ready", 32'(bus.if_ready), 1);
        check("ar_rel_valid", 32'(bus.out_valid), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
